load_store_controller: RTL

//  Sequences one RV32 load/store at a time between the core MEM stage and a word-wide data-memory port.
//  - Aligns store data and builds byte strobes; aligns and sign/zero-extends load data per funct3.
//  - Runs a single-outstanding req/ack handshake toward memory.
//  - Flags illegal or misaligned accesses with a fault instead of issuing them.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/load_store_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode for the RV32 load/store controller.
// Consumed by load_store_controller and lsu_load_align.
package lsu_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BUS, BUS2, RESP} lsu_state_t;

    // Access size in bytes; 0 marks an encoding with no defined size.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            2'b10:   size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            funct3_legal = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        end else begin
            funct3_legal = (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
                           (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
        end
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word from one or two read words and extends it.
// word_hi carries the low three bytes of the following word for boundary-crossing loads.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_lo,
    input  logic [23:0] word_hi,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] merged_s;

    // Little-endian byte merge starting at the access offset, then extension.
    always_comb begin
        merged_s = word_lo;
        result   = 32'h0000_0000;
        case (offset)
            2'b00:   merged_s = word_lo;
            2'b01:   merged_s = {word_hi[7:0],  word_lo[31:8]};
            2'b10:   merged_s = {word_hi[15:0], word_lo[31:16]};
            2'b11:   merged_s = {word_hi[23:0], word_lo[31:24]};
            default: merged_s = word_lo;
        endcase
        case (funct3)
            FUNCT3_LB:  result = {{24{merged_s[7]}}, merged_s[7:0]};
            FUNCT3_LH:  result = {{16{merged_s[15]}}, merged_s[15:0]};
            FUNCT3_LW:  result = merged_s;
            FUNCT3_LBU: result = {24'h00_0000, merged_s[7:0]};
            FUNCT3_LHU: result = {16'h0000, merged_s[15:0]};
            default:    result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_controller.sv
// Single-outstanding RV32 load/store sequencer between the MEM stage and a word-wide memory port.
// Define MISALIGNED_SPLIT_EN to run word-crossing halfword/word accesses as two bus beats.
module load_store_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata
);

    lsu_state_t      state_r;
    logic            is_store_r;
    logic [2:0]      funct3_r;
    logic [1:0]      offset_r;
    logic [2:0]      size_s;
    logic [3:0]      mask_s;
    logic [3:0]      strb_s;
    logic [XLEN-1:0] repl_s;
    logic [XLEN-1:0] wdata_s;
    logic            legal_s;
    logic            misaligned_s;
    logic            fault_s;
    logic [31:0]     align_lo_s;
    logic [23:0]     align_hi_s;
    logic [31:0]     load_result_s;
`ifdef MISALIGNED_SPLIT_EN
    logic              split_r;
    logic [XLEN-1:0]   wdata_hi_r;
    logic [3:0]        wstrb_hi_r;
    logic [XLEN-1:0]   rdata_lo_r;
    logic              crosses_s;
    logic [7:0]        strb_wide_s;
    logic [2*XLEN-1:0] data_wide_s;
`endif

    // Decode the incoming request: legality, alignment, strobes and lane data.
    always_comb begin
        size_s       = size_bytes(req_funct3);
        legal_s      = funct3_legal(req_is_store, req_funct3);
        misaligned_s = ((size_s == 3'd2) && req_addr[0]) ||
                       ((size_s == 3'd4) && (req_addr[1:0] != 2'b00));
        case (size_s)
            3'd1:    mask_s = 4'b0001;
            3'd2:    mask_s = 4'b0011;
            3'd4:    mask_s = 4'b1111;
            default: mask_s = 4'b0000;
        endcase
        case (req_funct3[1:0])
            2'b00:   repl_s = {4{req_wdata[7:0]}};
            2'b01:   repl_s = {2{req_wdata[15:0]}};
            default: repl_s = req_wdata;
        endcase
`ifdef MISALIGNED_SPLIT_EN
        strb_wide_s = {4'b0000, mask_s} << req_addr[1:0];
        data_wide_s = {{XLEN{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000};
        crosses_s   = ({1'b0, req_addr[1:0]} + size_s) > 3'd4;
        strb_s      = strb_wide_s[3:0];
        // Replication only lines up for naturally aligned data; otherwise shift into lanes.
        wdata_s     = misaligned_s ? data_wide_s[XLEN-1:0] : repl_s;
        fault_s     = !legal_s;
`else
        strb_s      = mask_s << req_addr[1:0];
        wdata_s     = repl_s;
        fault_s     = !legal_s || misaligned_s;
`endif
    end

    // Align source: the first word is held across a split, the last word is taken live on ack.
    always_comb begin
`ifdef MISALIGNED_SPLIT_EN
        align_lo_s = (state_r == BUS2) ? rdata_lo_r : mem_rdata;
        align_hi_s = mem_rdata[23:0];
`else
        align_lo_s = mem_rdata;
        align_hi_s = 24'h00_0000;
`endif
    end

    lsu_load_align u_align (
        .word_lo (align_lo_s),
        .word_hi (align_hi_s),
        .offset  (offset_r),
        .funct3  (funct3_r),
        .result  (load_result_s)
    );

    // Controller FSM with registered request latch, bus outputs and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            is_store_r <= 1'b0;
            funct3_r   <= 3'b000;
            offset_r   <= 2'b00;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= {XLEN{1'b0}};
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_WIDTH{1'b0}};
            mem_wdata  <= {XLEN{1'b0}};
            mem_wstrb  <= 4'b0000;
`ifdef MISALIGNED_SPLIT_EN
            split_r    <= 1'b0;
            wdata_hi_r <= {XLEN{1'b0}};
            wstrb_hi_r <= 4'b0000;
            rdata_lo_r <= {XLEN{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        is_store_r <= req_is_store;
                        funct3_r   <= req_funct3;
                        offset_r   <= req_addr[1:0];
                        req_ready  <= 1'b0;
                        if (fault_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= {XLEN{1'b0}};
                        end else begin
                            state_r   <= BUS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= req_is_store ? wdata_s : {XLEN{1'b0}};
                            mem_wstrb <= req_is_store ? strb_s : 4'b0000;
`ifdef MISALIGNED_SPLIT_EN
                            split_r    <= crosses_s;
                            wdata_hi_r <= data_wide_s[2*XLEN-1:XLEN];
                            wstrb_hi_r <= req_is_store ? strb_wide_s[7:4] : 4'b0000;
`endif
                        end
                    end
                end
                BUS, BUS2: begin
                    if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
                        if ((state_r == BUS) && split_r) begin
                            state_r    <= BUS2;
                            mem_addr   <= mem_addr + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
                            mem_wdata  <= wdata_hi_r;
                            mem_wstrb  <= wstrb_hi_r;
                            rdata_lo_r <= mem_rdata;
                        end else
`endif
                        begin
                            state_r    <= RESP;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= {ADDR_WIDTH{1'b0}};
                            mem_wdata  <= {XLEN{1'b0}};
                            mem_wstrb  <= 4'b0000;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b0;
                            resp_rdata <= is_store_r ? {XLEN{1'b0}} : load_result_s;
                        end
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= {XLEN{1'b0}};
                end
                default: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule
